// File: rtl/rd_data_ctrl.sv
// rd_data_ctrl: issues one DDR read burst per committed ring-buffer burst and forwards the returned words
module rd_data_ctrl #(
    parameter int BURST_WORDS = 8000,
    parameter int BURST_BYTES = 32000,
    parameter int RING_BYTES  = 192_000_000,
    parameter int RING_BURSTS = RING_BYTES / BURST_BYTES
) (
    input  logic        pl_clk,
    input  logic        rst,
    input  logic        rd_enable,
    input  logic        wr_burst_done,
    input  logic        out_ready,
    output logic        pl_ddr_rd_start,
    output logic [31:0] pl_ddr_rd_addr,
    output logic [31:0] pl_ddr_rd_length,
    input  logic        pl_ddr_rd_data_en,
    input  logic [31:0] pl_ddr_rd_data,
    input  logic        pl_ddr_rd_done,
    output logic        out_data_en,
    output logic [31:0] out_data,
    output logic [12:0] avail_bursts,
    output logic        overrun,
    output logic        burst_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, XFER, NEXT} state_t;
    state_t state, state_nx;
    logic [31:0] rd_addr;
    logic [12:0] word_cnt, cnt_inc;
    logic xfer, accept, drain;
    assign pl_ddr_rd_length = 32'(BURST_BYTES);
    assign pl_ddr_rd_start = state == ISSUE;
    assign xfer = state == XFER;
    assign accept = xfer && pl_ddr_rd_data_en;
    assign cnt_inc = (pl_ddr_rd_data_en && word_cnt != '1) ? word_cnt + 13'd1 : word_cnt;
    // next state: one IDLE->ISSUE->XFER->NEXT pass per burst
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (rd_enable && out_ready && avail_bursts != '0) ? ISSUE : IDLE;
            ISSUE:   state_nx = XFER;
            XFER:    state_nx = pl_ddr_rd_done ? NEXT : XFER;
            NEXT:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // state, datapath, credits and sticky flags; drain marks a burst cut off by reset so its leftovers are ignored
    always_ff @(posedge pl_clk) begin
        if (rst) begin
            state <= IDLE;
            rd_addr <= '0;
            word_cnt <= '0;
            pl_ddr_rd_addr <= '0;
            out_data_en <= 1'b0;
            out_data <= '0;
            avail_bursts <= '0;
            overrun <= 1'b0;
            burst_err <= 1'b0;
            drain <= drain || state == ISSUE || xfer;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == ISSUE) pl_ddr_rd_addr <= rd_addr;
            if (state == ISSUE) word_cnt <= '0;
            else if (accept) word_cnt <= cnt_inc;
            if (state == NEXT)
                rd_addr <= (rd_addr == 32'(RING_BYTES - BURST_BYTES)) ? '0 : rd_addr + 32'(BURST_BYTES);
            out_data_en <= accept;
            if (accept) out_data <= pl_ddr_rd_data;
            if ((pl_ddr_rd_data_en && !xfer && !drain) ||
                (xfer && pl_ddr_rd_done && cnt_inc != 13'(BURST_WORDS))) burst_err <= 1'b1;
            if (pl_ddr_rd_done || state == ISSUE) drain <= 1'b0;
            if (wr_burst_done && !pl_ddr_rd_start) begin
                if (avail_bursts == 13'(RING_BURSTS)) overrun <= 1'b1;
                else avail_bursts <= avail_bursts + 13'd1;
            end else if (!wr_burst_done && pl_ddr_rd_start) avail_bursts <= avail_bursts - 13'd1;
        end
    end
endmodule

// File: tb/tb_rd_data_ctrl.sv
// tb_rd_data_ctrl: randomized bench with a burst-level reference model and a read-engine responder
module tb_rd_data_ctrl;
    localparam int BW = 8000;
    localparam int BB = 32000;
    localparam int RN = 6000;

    logic        pl_clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_enable = 1'b0;
    logic        wr_burst_done = 1'b0;
    logic        out_ready = 1'b0;
    logic        pl_ddr_rd_start;
    logic [31:0] pl_ddr_rd_addr;
    logic [31:0] pl_ddr_rd_length;
    logic        pl_ddr_rd_data_en = 1'b0;
    logic [31:0] pl_ddr_rd_data = '0;
    logic        pl_ddr_rd_done = 1'b0;
    logic        out_data_en;
    logic [31:0] out_data;
    logic [12:0] avail_bursts;
    logic        overrun;
    logic        burst_err;

    always #5 pl_clk = ~pl_clk;

    rd_data_ctrl dut (
        .pl_clk(pl_clk), .rst(rst), .rd_enable(rd_enable), .wr_burst_done(wr_burst_done),
        .out_ready(out_ready), .pl_ddr_rd_start(pl_ddr_rd_start), .pl_ddr_rd_addr(pl_ddr_rd_addr),
        .pl_ddr_rd_length(pl_ddr_rd_length), .pl_ddr_rd_data_en(pl_ddr_rd_data_en),
        .pl_ddr_rd_data(pl_ddr_rd_data), .pl_ddr_rd_done(pl_ddr_rd_done), .out_data_en(out_data_en),
        .out_data(out_data), .avail_bursts(avail_bursts), .overrun(overrun), .burst_err(burst_err)
    );

    // read-engine responder configuration
    int          eng_len = BW;
    bit          eng_rand = 1'b0;
    bit          eng_gaps = 1'b0;
    logic [31:0] eng_base = '0;
    int          eng_cnt = 0;
    int          eng_i = 0;
    int          stray_req = 0;
    int          stray_ack = 0;

    // literal-expectation mailbox from the sequencer to the checker
    string       lit_name = "";
    int          lit_sel = 0;
    logic [31:0] lit_exp = '0;
    int          lit_req = 0;
    int          lit_ack = 0;

    int vec = 0;
    int mis = 0;

    // reference model state
    bit          armed = 1'b0;
    int          e_avail, words, nburst, cool, starts, dut_starts;
    bit          e_ov, e_err, e_start, e_oen, busy, ign;
    logic [31:0] e_addr, e_odata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // read engine: answers each start pulse with a burst, or emits a stray strobe on request
    initial begin
        int n;
        bit co;
        forever begin
            @(posedge pl_clk); #1;
            pl_ddr_rd_done = 1'b0;
            if (pl_ddr_rd_start) begin
                n = eng_rand ? int'($urandom_range(1)) : eng_len;
                co = (n > 0) && ($urandom_range(1) == 1);
                eng_i = 0;
                while (eng_i < n) begin
                    @(posedge pl_clk); #1;
                    if (eng_gaps && $urandom_range(3) == 0) pl_ddr_rd_data_en = 1'b0;
                    else begin
                        pl_ddr_rd_data_en = 1'b1;
                        pl_ddr_rd_data = eng_base + 32'(eng_i);
                        eng_i++;
                    end
                    pl_ddr_rd_done = co && eng_i == n;
                end
                if (!co) begin
                    @(posedge pl_clk); #1;
                    pl_ddr_rd_data_en = 1'b0;
                    pl_ddr_rd_done = 1'b1;
                end
                eng_cnt++;
            end else if (stray_req != stray_ack) begin
                pl_ddr_rd_data_en = 1'b1;
                pl_ddr_rd_data = $urandom;
                stray_ack++;
            end else pl_ddr_rd_data_en = 1'b0;
        end
    end

    // checker: compares every cycle against the model, then advances the model by one edge
    always @(negedge pl_clk) begin
        logic [31:0] act, mdl;
        bit nxt, xfer, acc, free;
        if (armed) begin
            chk("start", 32'(pl_ddr_rd_start), 32'(e_start));
            chk("addr", pl_ddr_rd_addr, e_addr);
            chk("length", pl_ddr_rd_length, 32'(BB));
            chk("avail", 32'(avail_bursts), 32'(e_avail));
            chk("overrun", 32'(overrun), 32'(e_ov));
            chk("burst_err", 32'(burst_err), 32'(e_err));
            chk("out_en", 32'(out_data_en), 32'(e_oen));
            chk("out_data", out_data, e_odata);
            if (pl_ddr_rd_start) dut_starts++;
            if (e_start) begin
                if (starts == 0) chk("addr_first", pl_ddr_rd_addr, 32'd0);
                if (starts == 1) chk("addr_second", pl_ddr_rd_addr, 32'd32000);
                if (starts == 5999) chk("addr_last", pl_ddr_rd_addr, 32'd191968000);
                if (starts == 6000) chk("addr_wrap", pl_ddr_rd_addr, 32'd0);
                starts++;
            end
            if (lit_req != lit_ack) begin
                act = lit_sel == 0 ? 32'(avail_bursts) : lit_sel == 1 ? 32'(overrun) :
                      lit_sel == 2 ? 32'(burst_err) : lit_sel == 3 ? 32'(out_data_en) :
                      lit_sel == 5 ? out_data : lit_sel == 6 ? 32'(dut_starts) : 32'd1;
                mdl = lit_sel == 0 ? 32'(e_avail) : lit_sel == 1 ? 32'(e_ov) :
                      lit_sel == 2 ? 32'(e_err) : lit_sel == 3 ? 32'(e_oen) :
                      lit_sel == 5 ? e_odata : 32'(starts);
                chk(lit_name, act, lit_exp);
                if (lit_sel != 4) chk({lit_name, "_model"}, mdl, lit_exp);
                lit_ack = lit_req;
            end
        end
        if (rst) begin
            ign = ign || busy;
            e_avail = 0; e_ov = 0; e_err = 0; e_start = 0; e_oen = 0;
            e_addr = '0; e_odata = '0; busy = 0; cool = 0; words = 0; nburst = 0;
            starts = 0; dut_starts = 0;
            armed = 1'b1;
        end else if (armed) begin
            free = !busy && cool == 0;
            xfer = busy && !e_start;
            nxt = free && rd_enable && out_ready && e_avail > 0;
            if (cool > 0) cool--;
            if (wr_burst_done && !e_start) begin
                if (e_avail == RN) e_ov = 1;
                else e_avail++;
            end else if (!wr_burst_done && e_start) e_avail--;
            acc = xfer && pl_ddr_rd_data_en;
            e_oen = acc;
            if (acc) e_odata = pl_ddr_rd_data;
            if (acc && words < 8191) words++;
            if (pl_ddr_rd_data_en && !xfer && !ign) e_err = 1;
            if (xfer && pl_ddr_rd_done) begin
                if (words != BW) e_err = 1;
                busy = 0;
                cool = 1;
                nburst++;
            end
            if (pl_ddr_rd_done || e_start) ign = 0;
            if (nxt) begin
                e_addr = 32'((nburst % RN) * BB);
                busy = 1;
                words = 0;
            end
            e_start = nxt;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge pl_clk); #1;
        end
    endtask

    task automatic lit(input string nm, input int sel, input logic [31:0] exp);
        lit_name = nm;
        lit_sel = sel;
        lit_exp = exp;
        lit_req++;
        cyc(1);
    endtask

    task automatic pulse_wr();
        wr_burst_done = 1'b1;
        cyc(1);
        wr_burst_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic wait_bursts(input int target, input int budget, input string nm);
        int k = 0;
        while (eng_cnt < target && k < budget) begin
            cyc(1);
            k++;
        end
        if (eng_cnt < target) lit(nm, 4, 0);
    endtask

    task automatic wait_start(input string nm);
        int k = 0;
        while (!pl_ddr_rd_start && k < 50) begin
            cyc(1);
            k++;
        end
        if (!pl_ddr_rd_start) lit(nm, 4, 0);
    endtask

    // sequencer
    initial begin
        int base;
        int k;
        cyc(3);
        rst = 1'b0;
        lit("rst_avail", 0, 0);
        lit("rst_overrun", 1, 0);
        lit("rst_err", 2, 0);
        lit("rst_out_en", 3, 0);

        // one full burst, data = word index
        eng_len = BW; eng_base = '0; eng_gaps = 1'b0;
        rd_enable = 1'b1; out_ready = 1'b1;
        base = eng_cnt;
        pulse_wr();
        wait_bursts(base + 1, 9000, "t1_timeout");
        cyc(4);
        lit("t1_err", 2, 0);
        lit("t1_avail", 0, 0);
        lit("t1_last_word", 5, 7999);

        // no credits: nothing issues
        cyc(10000);
        lit("t2_avail", 0, 0);
        lit("t2_starts", 6, 1);

        // ring wrap with short random bursts and random write timing
        do_reset();
        eng_rand = 1'b1; eng_gaps = 1'b1; eng_base = $urandom;
        base = eng_cnt;
        for (int i = 0; i < 6001; i++) begin
            wr_burst_done = 1'b1;
            cyc(1);
            wr_burst_done = 1'b0;
            cyc($urandom_range(3));
        end
        wait_bursts(base + 6001, 40000, "t3_timeout");
        cyc(4);
        lit("t3_overrun", 1, 0);
        lit("t3_avail", 0, 0);
        lit("t3_starts", 6, 6001);

        // credit saturation and coincident increment/decrement
        do_reset();
        eng_rand = 1'b0; eng_gaps = 1'b0; eng_len = 0;
        out_ready = 1'b0;
        wr_burst_done = 1'b1;
        cyc(6001);
        wr_burst_done = 1'b0;
        lit("t4_avail_sat", 0, 6000);
        lit("t4_overrun", 1, 1);
        out_ready = 1'b1;
        wait_start("t4_start1_timeout");
        cyc(1);
        wait_start("t4_start2_timeout");
        wr_burst_done = 1'b1;
        out_ready = 1'b0;
        cyc(1);
        wr_burst_done = 1'b0;
        lit("t4_coincident", 0, 5999);
        cyc(4);

        // short burst, then a stray strobe while idle
        do_reset();
        out_ready = 1'b1;
        eng_len = BW - 1; eng_base = $urandom;
        base = eng_cnt;
        pulse_wr();
        wait_bursts(base + 1, 9000, "t5_timeout");
        cyc(4);
        lit("t5_short_err", 2, 1);
        do_reset();
        cyc(2);
        stray_req++;
        cyc(3);
        lit("t5_stray_err", 2, 1);
        lit("t5_stray_out_en", 3, 0);

        // reset in the middle of a transfer
        do_reset();
        eng_len = 0;
        base = eng_cnt;
        pulse_wr();
        wait_bursts(base + 1, 50, "t6_first_timeout");
        cyc(4);
        eng_len = BW; eng_base = 32'h1000_0000;
        base = eng_cnt;
        pulse_wr();
        k = 0;
        while (!(eng_cnt == base && eng_i >= 100) && k < 300) begin
            cyc(1);
            k++;
        end
        if (!(eng_cnt == base && eng_i >= 100)) lit("t6_words_timeout", 4, 0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        lit("t6_rst_err", 2, 0);
        lit("t6_rst_out_en", 3, 0);
        wait_bursts(base + 1, 9000, "t6_abort_timeout");
        cyc(4);
        lit("t6_ignored_err", 2, 0);
        lit("t6_ignored_data", 5, 0);
        base = eng_cnt;
        pulse_wr();
        wait_bursts(base + 1, 9000, "t6_final_timeout");
        cyc(4);
        lit("t6_final_err", 2, 0);
        lit("t6_final_last", 5, 32'h1000_1F3F);
        lit("t6_final_starts", 6, 1);
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule

// File: doc/rd_data_ctrl.md
Name: rd_data_ctrl

Overview:
- Read-side counterpart of the PL DDR ring-buffer write path.
- Tracks how many 32000-byte bursts the write side has committed to the DDR ring buffer, and issues one read burst per committed burst to the PL DDR read engine, in order.
- Forwards the returned 32-bit words, registered, to the downstream upload path.
- Guards against underrun (reading uncommitted data), overrun (writer lapping reader) and short/long bursts.

Parameters:
- BURST_WORDS, 8000: 32-bit words per burst.
- BURST_BYTES, 32000: byte length per burst; address step; value driven on pl_ddr_rd_length.
- RING_BYTES, 192_000_000: ring size in bytes (100_000*6*320); must be a multiple of BURST_BYTES.
- RING_BURSTS, 6000: RING_BYTES/BURST_BYTES; capacity of the committed-burst counter.

Ports:
- pl_clk  in  1  DDR user-side clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_enable  in  1  level; 0 blocks new bursts (an in-flight burst completes).
- wr_burst_done  in  1  one-cycle pulse per burst fully written by the write side.
- out_ready  in  1  level; downstream can absorb one whole burst (BURST_WORDS words).
- pl_ddr_rd_start  out  1  one-cycle read-request pulse.
- pl_ddr_rd_addr  out  32  burst start byte address; valid while pl_ddr_rd_start=1.
- pl_ddr_rd_length  out  32  burst byte length.
- pl_ddr_rd_data_en  in  1  read engine data strobe.
- pl_ddr_rd_data  in  32  read engine data.
- pl_ddr_rd_done  in  1  one-cycle pulse; read engine finished the burst.
- out_data_en  out  1  registered copy of accepted pl_ddr_rd_data_en.
- out_data  out  32  registered copy of pl_ddr_rd_data.
- avail_bursts  out  13  committed, not-yet-issued bursts.
- overrun  out  1  sticky; writer lapped reader.
- burst_err  out  1  sticky; burst word count != BURST_WORDS at done.

Behaviour:
- Reset (synchronous, rst=1 at a pl_clk edge) clears all state; rst takes priority over all other inputs:
  - all outputs 0 except pl_ddr_rd_length=BURST_BYTES;
  - state=IDLE, read address=0, word counter=0.
- Reset mid-burst: immediate return to IDLE. Later rd_data_en/rd_done from the aborted burst are ignored.
- Credit counter avail_bursts:
  - +1 on wr_burst_done; -1 on the cycle pl_ddr_rd_start is asserted.
  - Both in the same cycle: unchanged.
  - Increment while at RING_BURSTS: hold at RING_BURSTS and set overrun.
- FSM: IDLE, ISSUE, XFER, NEXT.
  - IDLE -> ISSUE when rd_enable && out_ready && avail_bursts>0; otherwise stay.
  - ISSUE: pl_ddr_rd_start=1 for exactly this cycle, pl_ddr_rd_addr=current read address; clear word counter; -> XFER.
  - XFER:
    - each pl_ddr_rd_data_en=1 increments the word counter (13-bit, saturating at 8191);
    - word is forwarded to out_data/out_data_en with exactly 1 cycle latency;
    - on pl_ddr_rd_done -> NEXT; burst_err set if counter != BURST_WORDS, counting a data_en coincident with done.
  - NEXT: read address += BURST_BYTES, wrapping to 0 when current address == RING_BYTES-BURST_BYTES; -> IDLE.
  - Minimum gap between consecutive start pulses: 4 cycles.
- pl_ddr_rd_data_en outside XFER: word not forwarded (out_data_en stays 0), burst_err set.
- out_data updates only on accepted strobes; it holds its value otherwise.
- pl_ddr_rd_addr holds its last issued value outside ISSUE.
- rd_enable or out_ready dropping during XFER has no effect on the current burst.
- overrun and burst_err clear only on rst.

Test Plan:
- Reset, then one wr_burst_done, rd_enable=1, out_ready=1 -> start pulse with addr=0, length=32000; avail_bursts 1->0; 8000 data_en words (data=index) appear on out_data one cycle later, 0..7999; done -> burst_err=0, next address 32000.
- No wr_burst_done, rd_enable=1 -> no start pulse for 10000 cycles; avail_bursts=0.
- 6000 bursts written and read -> addresses 0, 32000, ..., 191_968_000, then 0; no overrun.
- 6001 wr_burst_done with out_ready=0 -> avail_bursts=6000, overrun=1; wr_burst_done coincident with start -> count unchanged.
- Burst of 7999 words then done -> burst_err=1; stray data_en in IDLE -> burst_err=1, out_data_en stays 0.
- rst asserted mid-XFER after 100 words -> next cycle all outputs at reset values; remaining words and done ignored; next burst issues at addr 0.
